// File: rtl/riscv_mdu_pkg.sv
// Shared definitions for the RISC-V M-extension multiply/divide unit.
// Contents: op encodings (equal to funct3), FSM state type, and
//           helpers deciding which operands are treated as signed.
package riscv_mdu_pkg;

  localparam logic [2:0] mdu_op_mul    = 3'd0;
  localparam logic [2:0] mdu_op_mulh   = 3'd1;
  localparam logic [2:0] mdu_op_mulhsu = 3'd2;
  localparam logic [2:0] mdu_op_mulhu  = 3'd3;
  localparam logic [2:0] mdu_op_div    = 3'd4;
  localparam logic [2:0] mdu_op_divu   = 3'd5;
  localparam logic [2:0] mdu_op_rem    = 3'd6;
  localparam logic [2:0] mdu_op_remu   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  // rs1 is signed for MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == mdu_op_mulh) || (op == mdu_op_mulhsu) ||
           (op == mdu_op_div)  || (op == mdu_op_rem);
  endfunction

  // rs2 is signed for MULH, DIV and REM (MULHSU treats it as unsigned)
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == mdu_op_mulh) || (op == mdu_op_div) || (op == mdu_op_rem);
  endfunction

endpackage

// File: rtl/riscv_mdu_div.sv
// Restoring-divide iteration: one shift/subtract step per enabled edge.
// Latency: WIDTH enabled edges after load; quo/rem then hold the unsigned result.
// Backpressure: none; the parent sequences load/en.
// Ports: clk, rst_n, load (capture dividend, clear remainder), en (one step),
//        dividend, divisor (held stable by parent while stepping), quo, rem.
module riscv_mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  // Partial remainder shifted left with the next dividend bit, minus divisor.
  // Bit WIDTH of the difference is the borrow: set means "restore".
  logic [WIDTH:0] trial;
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
    end else if (en) begin
      if (!trial[WIDTH]) rem <= trial[WIDTH-1:0];
      else               rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

endmodule

// File: rtl/riscv_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit (MUL..REMU).
// Latency: WIDTH+1 edges after accept; divide-by-zero/overflow (and all divides
//          when the divider is compiled out) finish 1 edge after accept.
// Backpressure: start is only sampled while idle; start during busy is dropped.
// Ports: clk, rst_n (async, active low), start, op (funct3), a, b ->
//        busy, done (1-cycle pulse), result (held), illegal.
// Build option: define RISCV_MDU_DIV_EN to include the divider; otherwise
//        divide ops complete at once with result 0 and illegal set.
module riscv_mdu
  import riscv_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   mag_a;   // multiplicand magnitude
  logic               neg_q;   // negate product / quotient in FIX
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;     // {partial sum, remaining multiplier bits}
  logic               fast;    // op decided in IDLE, skip CALC

  // Operand magnitudes with signedness chosen by op
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign a_neg = op_a_signed(op) & a[WIDTH-1];
  assign b_neg = op_b_signed(op) & b[WIDTH-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  // Shift-add step: add multiplicand if the current multiplier LSB is set,
  // then shift the whole accumulator right (carry enters the top).
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);

  logic               fast_now;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_res;

`ifdef RISCV_MDU_DIV_EN
  logic [WIDTH-1:0] mag_b;
  logic             neg_r;     // remainder takes the dividend's sign
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH-1:0] quo, rem;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] fast_val;

  assign div_zero = (b == '0);
  assign div_ovf  = ((op == mdu_op_div) || (op == mdu_op_rem)) &&
                    (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign fast_now = op[2] & (div_zero | div_ovf);
  // op[1] distinguishes REM/REMU from DIV/DIVU
  assign fast_val = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  riscv_mdu_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == ST_IDLE) && start && op[2]),
    .en       ((state == ST_CALC) && op_q[2]),
    .dividend (abs_a),
    .divisor  (mag_b),
    .quo      (quo),
    .rem      (rem)
  );

  assign illegal = 1'b0;
`else
  logic illegal_q;
  // Without a divider every divide op is resolved immediately as illegal
  assign fast_now = op[2];
  assign illegal  = illegal_q;
`endif

  always_comb begin
    prod    = neg_q ? -acc : acc;
    fix_res = (op_q == mdu_op_mul) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef RISCV_MDU_DIV_EN
    if (fast)         fix_res = fast_res;
    else if (op_q[2]) fix_res = op_q[1] ? (neg_r ? -rem : rem)
                                        : (neg_q ? -quo : quo);
`else
    if (fast)         fix_res = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      mag_a  <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      fast   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef RISCV_MDU_DIV_EN
      mag_b    <= '0;
      neg_r    <= 1'b0;
      fast_res <= '0;
`else
      illegal_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifndef RISCV_MDU_DIV_EN
      illegal_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            mag_a <= abs_a;
            neg_q <= a_neg ^ b_neg;
            cnt   <= '0;
            acc   <= {{WIDTH{1'b0}}, abs_b};
            fast  <= fast_now;
            busy  <= 1'b1;
`ifdef RISCV_MDU_DIV_EN
            mag_b    <= abs_b;
            neg_r    <= a_neg;
            fast_res <= fast_val;
`endif
            state <= fast_now ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (!op_q[2]) acc <= {mul_sum, acc[WIDTH-1:1]};
          if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          busy   <= 1'b0;
`ifndef RISCV_MDU_DIV_EN
          illegal_q <= fast;
`endif
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mdu.sv
// Scoreboard bench for riscv_mdu (WIDTH=32): driver pushes model results,
// a negedge monitor pops and compares whenever done is presented.
module tb_riscv_mdu;

`ifdef RISCV_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, illegal;
  logic [31:0] result;

  riscv_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // posedges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          acc_cyc;   // edge count after the accepting edge
    int          done_cyc;  // edge count after which done must be visible
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: M-extension semantics from plain 64-bit arithmetic
  function automatic void model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] r, output logic ill, output int lat);
    longint sa, sbv, q;
    bit [63:0] p;
    sa  = longint'($signed(ma));
    sbv = longint'($signed(mb));
    r = '0; ill = 1'b0; lat = 33; q = 0; p = '0;
    case (mop)
      3'd0: begin p = 64'(ma) * 64'(mb);           r = p[31:0];  end
      3'd1: begin p = sa * sbv;                    r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, mb});  r = p[63:32]; end
      3'd3: begin p = 64'(ma) * 64'(mb);           r = p[63:32]; end
      default: begin
        if (!DIV_EN) begin
          ill = 1'b1; lat = 1; r = '0;
        end else if (mb == 32'd0) begin
          lat = 1; r = mop[1] ? ma : 32'hFFFF_FFFF;
        end else if ((mop == 3'd4 || mop == 3'd6) && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
          lat = 1; r = mop[1] ? 32'd0 : ma;
        end else begin
          case (mop)
            3'd4:    q = sa / sbv;
            3'd5:    q = longint'({32'd0, ma}) / longint'({32'd0, mb});
            3'd6:    q = sa % sbv;
            default: q = longint'({32'd0, ma}) % longint'({32'd0, mb});
          endcase
          r = q[31:0];
        end
      end
    endcase
  endfunction

  // Wait (bounded) for idle, present one request for one cycle, log expectation
  task automatic issue(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib);
    exp_t e;
    int   lat;
    int   guard = 0;
    while (busy === 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        n_checks++; n_fail++;
        $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", guard);
        return;
      end
    end
    model(iop, ia, ib, e.res, e.ill, lat);
    e.acc_cyc  = cyc + 1;
    e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
    start = 1'b1; op = iop; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Monitor: compare at every done, and busy while an op is in flight
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_done: done=1 with nothing outstanding, expected 0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result",     result, e.res);
          check("illegal",    32'(illegal), 32'(e.ill));
          check("done_edge",  32'(cyc), 32'(e.done_cyc));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].acc_cyc) begin
        check("busy_in_flight", 32'(busy), 32'd1);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_outstanding", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_result",  result,       32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FF9C, 32'd7);
    issue(3'd6, 32'hFFFF_FF9C, 32'd7);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd7, 32'd5, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd4, 32'd9, 32'd3);

    // start pulsed mid-operation must be ignored
    issue(3'd0, 32'd123, 32'd456);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    // back-to-back: issue() fires in the done cycle of the previous op
    issue(3'd1, 32'hFFFF_FFF0, 32'd3);
    issue(3'd0, 32'd11, 32'd13);
    drain();

    // Asynchronous reset mid-CALC
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_busy",   32'(busy), 32'd0);
    check("async_rst_done",   32'(done), 32'd0);
    check("async_rst_result", result,    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd0, 32'd6, 32'd7);
    drain();

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom), pick(), pick());
    end
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
